// File: rtl/dbus_sram_if.sv
// -----------------------------------------------------------------------------
// dbus_sram_if
//   Core data-bus (DBus) signal bundle between the load/store unit (master)
//   and a memory responder (slave).
//
//   Handshake: the master raises dbus_rd_en or dbus_wr_en together with
//   dbus_addr / dbus_wr_data / dbus_wr_strobe and holds all of them steady
//   while dbus_wait is high. The transaction completes in the first cycle in
//   which a request is present and dbus_wait is low. In that cycle,
//   dbus_rd_data holds the right-justified load data and dbus_err marks an
//   aborted access. Any request still present in the following cycle starts
//   a new transaction.
//
//   Signals
//     dbus_rd_en      master->slave  read request
//     dbus_wr_en      master->slave  write request
//     dbus_addr       master->slave  byte address
//     dbus_wr_data    master->slave  store data, right-justified
//     dbus_wr_strobe  master->slave  store size (1 byte, 3 half, F word)
//     dbus_rd_data    slave->master  load data, right-justified
//     dbus_wait       slave->master  transaction not yet complete
//     dbus_err        slave->master  transaction aborted (completion only)
// -----------------------------------------------------------------------------
interface dbus_sram_if;
   logic        dbus_rd_en;
   logic        dbus_wr_en;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wr_data;
   logic [3:0]  dbus_wr_strobe;
   logic [31:0] dbus_rd_data;
   logic        dbus_wait;
   logic        dbus_err;

   modport master (
      output dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
      input  dbus_rd_data, dbus_wait, dbus_err
   );

   modport slave (
      input  dbus_rd_en, dbus_wr_en, dbus_addr, dbus_wr_data, dbus_wr_strobe,
      output dbus_rd_data, dbus_wait, dbus_err
   );
endinterface

// File: rtl/dbus_sram.sv
// -----------------------------------------------------------------------------
// dbus_sram
//   DBus responder backing a word-organised, little-endian RAM window at
//   BASE_ADDR. Store data/strobes arrive byte-lane-0 aligned and are steered
//   to the addressed lanes; load data is returned right-justified. Bus errors
//   are raised for out-of-range, illegal-strobe, lane-overflow and
//   simultaneous read+write requests.
//
//   Ports
//     clk          clock, rising edge
//     rst          asynchronous, active-high reset
//     dbus         dbus_sram_if.slave bundle (request in, response out)
//     dbg_state_o  current FSM state (IDLE=0, BUSY=1, ACK=2)
//
//   Parameters
//     BASE_ADDR    byte address of word 0 (4-byte aligned)
//     DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//     WAIT_STATES  extra stall cycles between accept and completion (0..15)
// -----------------------------------------------------------------------------
module dbus_sram #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_STATES = 0
) (
   input  logic             clk,
   input  logic             rst,
   dbus_sram_if.slave       dbus,
   output logic [1:0]       dbg_state_o
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_BUSY   = 2'd1;
   localparam logic [1:0]  S_ACK    = 2'd2;
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   // Upper bound held at 33 bits so a window ending at 4 GiB does not wrap.
   localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          rd_q, wr_q, err_q;
   logic [1:0]    off_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [3:0]    strb_q;
   logic [31:0]   rdata_q;

   logic          req;
   logic [1:0]    off;
   logic [AW-1:0] idx;
   logic          in_range;
   logic [7:0]    strb_sh;
   logic          strb_ok;
   logic          err_now;

   // ---------------- request decode (live inputs, used at accept) ----------
   always_comb begin
      req      = dbus.dbus_rd_en | dbus.dbus_wr_en;
      off      = dbus.dbus_addr[1:0];
      idx      = AW'((dbus.dbus_addr - BASE_ADDR) >> 2);
      in_range = ({1'b0, dbus.dbus_addr} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, dbus.dbus_addr} < LIMIT);
      // Shifted at 8 bits so a lane overflow past bit 3 is visible.
      strb_sh  = {4'b0000, dbus.dbus_wr_strobe} << off;
      strb_ok  = (dbus.dbus_wr_strobe == 4'h1) || (dbus.dbus_wr_strobe == 4'h3) ||
                 (dbus.dbus_wr_strobe == 4'hF);
      err_now  = (dbus.dbus_rd_en & dbus.dbus_wr_en) | ~in_range |
                 (dbus.dbus_wr_en & (~strb_ok | (|strb_sh[7:4])));
   end

   // ---------------- next state ---------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = (WAIT_STATES > 0) ? S_BUSY : S_ACK;
               cnt_d   = CNT_INIT;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) state_d = S_ACK;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- state and capture registers ----------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         off_q   <= 2'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         strb_q  <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && req) begin
            rd_q    <= dbus.dbus_rd_en;
            wr_q    <= dbus.dbus_wr_en;
            err_q   <= err_now;
            off_q   <= off;
            idx_q   <= idx;
            wdata_q <= dbus.dbus_wr_data << {off, 3'b000};
            strb_q  <= strb_sh[3:0];
            if (in_range && !err_now) rdata_q <= mem[idx];
         end
      end
   end

   // ---------------- RAM write (not reset) ----------------------------------
   // Commits on the edge that ends ACK. A reset during the transaction forces
   // state_q to IDLE asynchronously, so the pending write is dropped.
   always_ff @(posedge clk) begin
      if (state_q == S_ACK && wr_q && !err_q) begin
         for (int i = 0; i < 4; i++) begin
            if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   // ---------------- outputs --------------------------------------------------
   always_comb begin
      dbus.dbus_wait    = 1'b0;
      dbus.dbus_err     = 1'b0;
      dbus.dbus_rd_data = 32'd0;
      case (state_q)
         // Gated by rst so all outputs read 0 while reset is held.
         S_IDLE: dbus.dbus_wait = req & ~rst;
         S_BUSY: dbus.dbus_wait = 1'b1;
         S_ACK: begin
            dbus.dbus_err = err_q;
            if (rd_q && !err_q) dbus.dbus_rd_data = rdata_q >> {off_q, 3'b000};
         end
         default: ;
      endcase
   end

   assign dbg_state_o = state_q;

endmodule

// File: doc/dbus_sram.md
Name: dbus_sram

Overview:
- DBus responder (target) for the core's load/store unit.
- Backs a word-organised, little-endian byte-lane RAM window at a parameterised base address, with configurable wait states.
- Performs byte-lane steering, because the LSU drives byte-lane 0-aligned store data/strobes and expects load data right-justified.
- Signals bus errors for out-of-range, illegal-strobe and conflicting requests.
- Sits between the core DBus and the system memory map.

Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 0, extra stall cycles inserted between accept and completion; range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dbus_rd_en  input  1  read request.
- dbus_wr_en  input  1  write request.
- dbus_addr  input  32  byte address.
- dbus_wr_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- dbus_wr_strobe  input  4  store size: 4'h1 byte, 4'h3 half, 4'hF word; unshifted.
- dbus_rd_data  output  32  load data, right-justified.
- dbus_wait  output  1  transaction not yet complete; initiator holds request.
- dbus_err  output  1  transaction aborted; valid in completion cycle only.

Behaviour:
- Reset is asynchronous and active-high: clock is clk, reset is rst.
  - On rst: state=IDLE, wait counter=0, all capture registers=0.
  - dbus_wait=0, dbus_err=0, dbus_rd_data=0 immediately.
  - RAM contents are not reset.
  - Reset mid-transaction discards the transaction; a pending write is not committed.
- req = dbus_rd_en | dbus_wr_en.
- off = addr[1:0]; idx = (addr - BASE_ADDR) >> 2.
- Address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, compared at 33-bit width (no wrap).
- Error conditions, evaluated at accept from live inputs and captured:
  - dbus_rd_en & dbus_wr_en both high.
  - Address out of range.
  - Write with strobe not in {1,3,F}.
  - Write with (strobe << off) overflowing bit 3, e.g. half at off=3 or word at off!=0.
- Reads have no size and never error on alignment.
- FSM states: IDLE, BUSY, ACK.
  - IDLE:
    - dbus_wait = req, combinational; dbus_err=0; dbus_rd_data=0.
    - On an edge with req: capture rd/wr, off, idx, wr_data << 8*off, strobe << off, and err flag.
    - Same edge, rdata_q <= RAM[idx] when in range and not error.
    - Go to BUSY with counter=WAIT_STATES-1 if WAIT_STATES>0, else go to ACK.
  - BUSY:
    - dbus_wait=1; counter decrements each cycle.
    - Go to ACK when counter==0.
    - Input changes are ignored; captured values are used.
  - ACK:
    - dbus_wait=0; dbus_err=captured err.
    - dbus_rd_data = (captured rd & !err) ? rdata_q >> 8*off : 0.
    - On the ending edge, if captured wr & !err, write RAM[idx] byte lanes where the shifted strobe bit is 1; other lanes unchanged.
    - Always return to IDLE.
- Latency: request-to-completion = 2 + WAIT_STATES cycles. dbus_wait is high for the first 1+WAIT_STATES cycles.
- Back-to-back: a request present in the cycle after ACK is a new transaction.
  - An initiator holding the same request past completion re-executes it; reads are idempotent, writes rewrite the same data.
- Read-after-write: a read accepted immediately after a write's ACK sees the written data.
- No byte swapping; endianness is handled by the initiator.
- dbus_err is never high while dbus_wait is high.

Test Plan:
- Reset behaviour: rst asserted mid-BUSY (WAIT_STATES=3) during a write of 32'hDEADBEEF to BASE_ADDR -> outputs go to 0 asynchronously; subsequent read of BASE_ADDR returns its prior value, not DEADBEEF.
- Word write then read (WAIT_STATES=0):
  - SW 32'h11223344 @ BASE_ADDR+8, then read @ BASE_ADDR+8 -> rd_data=32'h11223344.
  - dbus_wait high exactly 1 cycle per transaction; err=0.
- Byte/half lane steering:
  - SW 32'hAABBCCDD @ +4; SB 32'h000000EE @ +6; SH 32'h00001234 @ +4.
  - Read @ +4 -> 32'hAAEE1234.
  - Read @ +7 -> 32'h000000AA in [7:0].
- Errors, each giving err=1 in ACK with wait low, RAM unchanged and rd_data=0:
  - Read @ BASE_ADDR-4 or @ BASE_ADDR+4*DEPTH_WORDS.
  - SH at off=3.
  - SW at off=2.
  - Write with strobe 4'h5.
  - rd_en and wr_en both high.
- Wait-state count (WAIT_STATES=5): read -> dbus_wait high for exactly 6 cycles, then a single ACK cycle; inputs changed during BUSY do not affect the result.
- Back-to-back: SW 32'h1 @ +0, next cycle read @ +0, next cycle SW 32'h2 @ +0 -> read returns 32'h1; a final read returns 32'h2; no cycle lost between transactions.
